operand_gate_pipe: RTL and testbench

Parametrised multi-lane operand gating pipeline for the CPU datapath. Each lane of an incoming operand word is ANDed with its lane-enable bit, then carried through DEPTH register stages with valid tracking, stall (hold) and flush (bubble insertion). It sits between decode/register-read and execute, zeroing disabled lanes and squashed instructions so downstream units always see zero data on bubbles.

---
 rtl/operand_gate_pipe_if.sv | 25 ++
 rtl/operand_gate_pipe.sv | 70 +++++++
 tb/tb_operand_gate_pipe.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_gate_pipe_if.sv
// Operand pipe bus: upstream operand word with lane enables and stall/flush controls,
// downstream last-stage word and occupancy flag.
interface operand_gate_pipe_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
);
  logic                     in_valid;
  logic [LANES*WIDTH-1:0]   in_data;
  logic [LANES-1:0]         in_lane_en;
  logic                     stall;
  logic                     flush;
  logic                     out_valid;
  logic [LANES*WIDTH-1:0]   out_data;
  logic                     busy;

  modport master (
    output in_valid, in_data, in_lane_en, stall, flush,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_lane_en, stall, flush,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/operand_gate_pipe.sv
// Lane-gated DEPTH-stage operand pipe: latency DEPTH edges, stall holds every stage (upstream holds its word).
// Flush/reset clear all stages; OPGATE_SQUASH_CNT_EN adds a saturating 16-bit squashed-word counter.
module operand_gate_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  operand_gate_pipe_if.slave  bus
`ifdef OPGATE_SQUASH_CNT_EN
  ,
  output logic [15:0]         squash_count
`endif
);
  localparam int W = LANES * WIDTH;

  logic [DEPTH-1:0] v;
  logic [W-1:0]     d [DEPTH];
  logic [W-1:0]     gated;

  always_comb begin
    gated = '0;
    for (int i = 0; i < LANES; i++) begin
      gated[i*WIDTH +: WIDTH] = bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{bus.in_lane_en[i]}};
    end
  end

  // Bubbles are written with zero data so v[s] == 0 always implies d[s] == 0.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      v <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        d[s] <= '0;
      end
    end else if (!bus.stall) begin
      v[0] <= bus.in_valid;
      d[0] <= bus.in_valid ? gated : '0;
      for (int s = 1; s < DEPTH; s++) begin
        v[s] <= v[s-1];
        d[s] <= d[s-1];
      end
    end
  end

  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.busy      = |v;

`ifdef OPGATE_SQUASH_CNT_EN
  logic [16:0] squash_add;
  logic [16:0] squash_sum;

  always_comb begin
    squash_add = 17'(bus.in_valid);
    for (int s = 0; s < DEPTH; s++) begin
      squash_add = squash_add + 17'(v[s]);
    end
    squash_sum = {1'b0, squash_count} + squash_add;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_count <= '0;
    end else if (bus.flush) begin
      squash_count <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_operand_gate_pipe.sv
// Directed bench for operand_gate_pipe with a queue-based reference pipe and literal spot checks.
module tb_operand_gate_pipe;
  localparam int WIDTH = 16;
  localparam int LANES = 2;
  localparam int DEPTH = 2;
  localparam int W     = LANES * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_gate_pipe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

`ifdef OPGATE_SQUASH_CNT_EN
  logic [15:0] squash_count;
`endif

  operand_gate_pipe #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
`ifdef OPGATE_SQUASH_CNT_EN
    ,
    .squash_count(squash_count)
`endif
  );

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference: a list of DEPTH slots, newest at the front, output at the back.
  typedef struct { bit v; logic [W-1:0] d; } ent_t;
  ent_t mq[$];
  int   mcnt = 0;

  function automatic logic [W-1:0] gate(input logic [W-1:0] dat, input logic [LANES-1:0] en);
    logic [W-1:0] r = '0;
    for (int i = 0; i < LANES; i++)
      if (en[i]) r[i*WIDTH +: WIDTH] = dat[i*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic void model_clear();
    ent_t e;
    e.v = 1'b0;
    e.d = '0;
    mq.delete();
    for (int s = 0; s < DEPTH; s++) mq.push_front(e);
  endfunction

  initial model_clear();

  always @(posedge clk) begin
    ent_t e;
    int   n;
    if (rst) begin
      model_clear();
      mcnt = 0;
    end else if (bus.flush) begin
      n = int'(bus.in_valid);
      foreach (mq[k]) n += int'(mq[k].v);
      mcnt = (mcnt + n > 65535) ? 65535 : mcnt + n;
      model_clear();
    end else if (!bus.stall) begin
      e.v = bus.in_valid;
      e.d = bus.in_valid ? gate(bus.in_data, bus.in_lane_en) : '0;
      void'(mq.pop_back());
      mq.push_front(e);
    end
  end

  always @(negedge clk) begin
    bit any;
    if (chk_en) begin
      any = 1'b0;
      foreach (mq[k]) any |= mq[k].v;
      chk("model_out_valid", 64'(bus.out_valid), 64'(mq[DEPTH-1].v));
      chk("model_out_data",  64'(bus.out_data),  64'(mq[DEPTH-1].d));
      chk("model_busy",      64'(bus.busy),      64'(any));
`ifdef OPGATE_SQUASH_CNT_EN
      chk("model_squash", 64'(squash_count), 64'(mcnt));
`endif
    end
  end

  task automatic drive(input bit vld, input logic [W-1:0] dat, input logic [LANES-1:0] en,
                       input bit st, input bit fl);
    bus.in_valid   = vld;
    bus.in_data    = dat;
    bus.in_lane_en = en;
    bus.stall      = st;
    bus.flush      = fl;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input bit ov, input logic [W-1:0] od, input bit bz);
    chk({name, "_valid"}, 64'(bus.out_valid), 64'(ov));
    chk({name, "_data"},  64'(bus.out_data),  64'(od));
    chk({name, "_busy"},  64'(bus.busy),      64'(bz));
  endtask

  typedef struct { bit vld; logic [W-1:0] dat; logic [LANES-1:0] en; bit st; bit fl; } vec_t;
  vec_t vecs[12] = '{
    '{1'b1, 32'h0102_0304, 2'b11, 1'b0, 1'b0},
    '{1'b1, 32'h0506_0708, 2'b10, 1'b0, 1'b0},
    '{1'b1, 32'h090A_0B0C, 2'b01, 1'b0, 1'b0},
    '{1'b1, 32'hDEAD_BEEF, 2'b11, 1'b1, 1'b0},
    '{1'b1, 32'hDEAD_BEEF, 2'b11, 1'b0, 1'b0},
    '{1'b0, 32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0},
    '{1'b1, 32'h1357_9BDF, 2'b11, 1'b0, 1'b0},
    '{1'b1, 32'h2468_ACE0, 2'b11, 1'b1, 1'b1},
    '{1'b1, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b0},
    '{1'b0, 32'h0000_0000, 2'b00, 1'b1, 1'b0},
    '{1'b1, 32'h7777_8888, 2'b00, 1'b0, 1'b0},
    '{1'b0, 32'h0000_0000, 2'b11, 1'b0, 1'b0}
  };

  initial begin
    drive(1'b1, 32'hFFFF_FFFF, 2'b11, 1'b0, 1'b0);
    rst = 1'b1;

    tick();
    chk_out("rst_c0", 1'b0, '0, 1'b0);
`ifdef OPGATE_SQUASH_CNT_EN
    chk("rst_squash", 64'(squash_count), 64'd0);
`endif
    chk_en = 1'b1;
    tick();
    chk_out("rst_c1", 1'b0, '0, 1'b0);
    rst = 1'b0;
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0);
    tick();
    chk_out("post_rst", 1'b0, '0, 1'b0);

    // Gating and latency: lane 1 disabled.
    drive(1'b1, 32'hABCD_1234, 2'b01, 1'b0, 1'b0);
    tick();
    chk("gate_c1_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0);
    tick();
    chk_out("gate_c2", 1'b1, 32'h0000_1234, 1'b1);
    tick();
    chk("gate_c3_valid", 64'(bus.out_valid), 64'd0);
    drive(1'b1, 32'hABCD_1234, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0);
    tick();
    chk_out("zero_lanes", 1'b1, 32'h0000_0000, 1'b1);
    tick();

    // Stall: A then B, three stall cycles.
    drive(1'b1, 32'h1111_2222, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3333_4444, 2'b11, 1'b0, 1'b0);
    tick();
    chk_out("stall_c2", 1'b1, 32'h1111_2222, 1'b1);
    drive(1'b0, '0, 2'b11, 1'b1, 1'b0);
    tick();
    chk_out("stall_c3", 1'b1, 32'h1111_2222, 1'b1);
    tick();
    chk_out("stall_c4", 1'b1, 32'h1111_2222, 1'b1);
    tick();
    chk_out("stall_c5", 1'b1, 32'h1111_2222, 1'b1);
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0);
    tick();
    chk_out("stall_c6", 1'b1, 32'h3333_4444, 1'b1);
    tick();
    chk_out("stall_c7", 1'b0, '0, 1'b0);
    drive(1'b0, '0, 2'b11, 1'b1, 1'b0);
    tick();
    chk_out("stall_empty", 1'b0, '0, 1'b0);

    // Flush with both stages valid and an incoming word.
    drive(1'b1, 32'hAAAA_BBBB, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hCCCC_DDDD, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h5555_6666, 2'b11, 1'b0, 1'b1);
    tick();
    chk_out("flush", 1'b0, '0, 1'b0);
`ifdef OPGATE_SQUASH_CNT_EN
    chk("flush_squash", 64'(squash_count), 64'd3);
`endif

    // Flush wins over stall.
    drive(1'b1, 32'h1234_5678, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h9ABC_DEF0, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0F0F_0F0F, 2'b11, 1'b1, 1'b1);
    tick();
    chk_out("flush_stall", 1'b0, '0, 1'b0);
`ifdef OPGATE_SQUASH_CNT_EN
    chk("flush_stall_squash", 64'(squash_count), 64'd6);
`endif

    // Reset wins over flush; flush does not count.
    drive(1'b1, 32'h4444_3333, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h2222_1111, 2'b11, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h2222_1111, 2'b11, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0);
    chk_out("rst_flush", 1'b0, '0, 1'b0);
`ifdef OPGATE_SQUASH_CNT_EN
    chk("rst_flush_squash", 64'(squash_count), 64'd0);
`endif

    foreach (vecs[k]) begin
      drive(vecs[k].vld, vecs[k].dat, vecs[k].en, vecs[k].st, vecs[k].fl);
      tick();
    end
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0);
    for (int k = 0; k < DEPTH + 1; k++) tick();

`ifdef OPGATE_SQUASH_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h0000_0001, 2'b11, 1'b0, 1'b1);
    for (int k = 0; k < 65534; k++) tick();
    chk("sat_fffe", 64'(squash_count), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(squash_count), 64'hFFFF);
    drive(1'b1, 32'h0000_0002, 2'b11, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, '0, 2'b11, 1'b0, 1'b1);
    tick();
    chk("sat_hold", 64'(squash_count), 64'hFFFF);
    drive(1'b0, '0, 2'b11, 1'b0, 1'b0);
    tick();
`endif

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
